// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 2;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SLTU = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b111;

    localparam logic [ST_W-1:0] S_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] S_EXEC1 = 2'd1;
    localparam logic [ST_W-1:0] S_ITER  = 2'd2;
    localparam logic [ST_W-1:0] S_DONE  = 2'd3;

    // MUL always iterates; DIVU only when the divisor is non-zero.
    function automatic logic is_iter_op(input logic [OP_W-1:0] op, input logic b_nonzero);
        return (op == OP_MUL) || ((op == OP_DIVU) && b_nonzero);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
module iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;

    // hi:lo is the product accumulator (MUL) or remainder:dividend/quotient (DIVU).
    always_comb begin
        sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        trial_c = {hi_q, lo_q[WIDTH-1]};
        diff_c  = trial_c - {1'b0, opnd_q};
        ge_c    = trial_c >= {1'b0, opnd_q};

        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (load) begin
            hi_d     = '0;
            lo_d     = op_a;
            opnd_d   = op_b;
            mode_d   = mode;
            cnt_d    = CNT_W'(WIDTH - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (mode_q) begin
                hi_d = WIDTH'(ge_c ? diff_c : trial_c);
                lo_d = {lo_q[WIDTH-2:0], ge_c};
            end else begin
                hi_d = sum_c[WIDTH:1];
                lo_d = {sum_c[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign res_lo = lo_q;
    assign res_hi = hi_q;
    assign done   = done_q;

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL and DIVU.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [OP_W-1:0]  ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             accept_c;
    logic             iter_load_c;
    logic [WIDTH-1:0] exec_lo_c;
    logic [WIDTH-1:0] exec_hi_c;
    logic             exec_dz_c;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic             iter_done;

    iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load_c),
        .mode   (ALUControl == OP_DIVU),
        .op_a   (SrcA),
        .op_b   (SrcB),
        .res_lo (iter_lo),
        .res_hi (iter_hi),
        .done   (iter_done)
    );

    // Single-cycle results from captured operands; DIVU here is only the divide-by-zero case.
    always_comb begin
        exec_lo_c = '0;
        exec_hi_c = '0;
        exec_dz_c = 1'b0;
        case (op_q)
            OP_AND:  exec_lo_c = a_q & b_q;
            OP_OR:   exec_lo_c = a_q | b_q;
            OP_ADD:  exec_lo_c = a_q + b_q;
            OP_SUB:  exec_lo_c = a_q - b_q;
            OP_SLTU: exec_lo_c = WIDTH'(a_q < b_q);
            OP_SLT:  exec_lo_c = WIDTH'($signed(a_q) < $signed(b_q));
            OP_DIVU: begin
                exec_lo_c = '1;
                exec_hi_c = a_q;
                exec_dz_c = 1'b1;
            end
            default: exec_lo_c = '0;
        endcase
    end

    always_comb begin
        accept_c    = Start && !busy_q && ((state_q == S_IDLE) || (state_q == S_DONE));
        iter_load_c = 1'b0;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    a_d  = SrcA;
                    b_d  = SrcB;
                    op_d = ALUControl;
                    // Divide-by-zero takes the one-cycle path so it shares the EXEC1 latency.
                    if (is_iter_op(ALUControl, |SrcB)) begin
                        iter_load_c = 1'b1;
                        state_d     = S_ITER;
                    end else begin
                        state_d = S_EXEC1;
                    end
                end
            end
            S_EXEC1: begin
                state_d     = S_DONE;
                done_d      = 1'b1;
                result_d    = exec_lo_c;
                result_hi_d = exec_hi_c;
                div_zero_d  = exec_dz_c;
                zero_d      = ~|exec_lo_c;
            end
            S_ITER: begin
                if (iter_done) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    div_zero_d  = 1'b0;
                    zero_d      = ~|iter_lo;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign ALUResult = result_q;
    assign ResultHi  = result_hi_q;
    assign Zero      = zero_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivZero   = div_zero_q;

endmodule
